// File: rtl/aes_key_share_loader.sv
// Splits a captured AES key into two Boolean shares and writes them word-by-word, or zeroises them; AES_KSL_MASK_EN selects masking.
// Latency: strobes on the NumWords cycles after accept/clear, done_o on the next, key_ready_o again the cycle after done.
// Backpressure: key_ready_o only in IDLE; clear_i preempts any load and is ignored while a clear is already running.
module aes_key_share_loader #(
    parameter int unsigned NumWords = 8,
    parameter logic [31:0] LfsrSeed = 32'hACE1_2468
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          key_valid_i,
    output logic                          key_ready_o,
    input  logic [32*NumWords-1:0]        key_i,
    input  logic                          clear_i,
    output logic [31:0]                   ks0_q_o,
    output logic [31:0]                   ks1_q_o,
    output logic [$clog2(NumWords)-1:0]   ks_idx_o,
    output logic                          ks_qe_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned IdxW = $clog2(NumWords);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic            qe;
        logic [IdxW-1:0] idx;
        logic [31:0]     ks0;
        logic [31:0]     ks1;
        logic            busy;
        logic            done;
    } out_t;

    state_e                       state_q, state_d;
    logic [IdxW-1:0]              idx_q, idx_d;
    logic [NumWords-1:0][31:0]    key_q, key_d;
    out_t                         out_q, out_d;

`ifdef AES_KSL_MASK_EN
    localparam logic [31:0] SeedEff = (LfsrSeed == 32'h0) ? 32'h0000_0001 : LfsrSeed;
    localparam logic [31:0] LfsrPoly = 32'h8020_0003;

    logic [31:0] lfsr_q, lfsr_d;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LfsrPoly) : (s >> 1);
    endfunction
`else
    logic unused_seed;
    assign unused_seed = ^LfsrSeed;
`endif

    // Outputs are built from the next state so they land in the same cycle as the state they describe.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        key_d   = key_q;
        out_d   = '0;
`ifdef AES_KSL_MASK_EN
        lfsr_d  = lfsr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    key_d   = '0;
                end else if (key_valid_i) begin
                    state_d = ST_WRITE;
                    idx_d   = '0;
                    key_d   = key_i;
                end
            end
            ST_WRITE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    key_d   = '0;
                end else if (idx_q == LastIdx) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                if (idx_q == LastIdx) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                key_d   = '0;
                idx_d   = '0;
                state_d = clear_i ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                key_d   = '0;
            end
        endcase

        out_d.qe   = (state_d == ST_WRITE) || (state_d == ST_CLEAR);
        out_d.busy = out_d.qe;
        out_d.idx  = idx_d;
        out_d.done = (state_d == ST_DONE);
        if (state_d == ST_WRITE) begin
`ifdef AES_KSL_MASK_EN
            out_d.ks1 = lfsr_q;
            out_d.ks0 = key_d[idx_d] ^ lfsr_q;
            lfsr_d    = lfsr_step(lfsr_q);
`else
            out_d.ks0 = key_d[idx_d];
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            key_q   <= '0;
            out_q   <= '0;
`ifdef AES_KSL_MASK_EN
            lfsr_q  <= SeedEff;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            out_q   <= out_d;
`ifdef AES_KSL_MASK_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign key_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign ks0_q_o     = out_q.ks0;
    assign ks1_q_o     = out_q.ks1;
    assign ks_idx_o    = out_q.idx;
    assign ks_qe_o     = out_q.qe;
    assign busy_o      = out_q.busy;
    assign done_o      = out_q.done;

endmodule

// File: tb/tb_aes_key_share_loader.sv
// Bench for aes_key_share_loader: directed vector table, then random traffic against a timeline model.
module tb_aes_key_share_loader;

    localparam int NW   = 8;
    localparam int MAXC = 4096;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam int K_FREE = 0, K_WR = 1, K_CL = 2, K_DN = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vld = 1'b0;
    logic              clr = 1'b0;
    logic [32*NW-1:0]  key = '0;
    logic              key_ready_o, ks_qe_o, busy_o, done_o;
    logic [31:0]       ks0_q_o, ks1_q_o;
    logic [2:0]        ks_idx_o;

    always #5 clk = ~clk;

    aes_key_share_loader #(.NumWords(NW), .LfsrSeed(SEED)) dut (
        .clk_i(clk), .rst_i(rst), .key_valid_i(vld), .key_ready_o(key_ready_o),
        .key_i(key), .clear_i(clr), .ks0_q_o(ks0_q_o), .ks1_q_o(ks1_q_o),
        .ks_idx_o(ks_idx_o), .ks_qe_o(ks_qe_o), .busy_o(busy_o), .done_o(done_o)
    );

    // Timeline model: what each future cycle is expected to show.
    int          kind [MAXC];
    int          eidx [MAXC];
    logic [31:0] eword[MAXC];
    logic [31:0] obs_ks0[MAXC];
    logic [31:0] obs_ks1[MAXC];
    logic [31:0] lfsr_m;
    int          cyc;
    int          n_chk, n_fail;

    typedef struct {
        logic r, v, c;
        int   ksel;
        int   e_rdy, e_qe, e_idx, e_done;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    function automatic void add(input logic r, v, c, input int ksel, e_rdy, e_qe, e_idx, e_done);
        vec_t t;
        t.r = r; t.v = v; t.c = c; t.ksel = ksel;
        t.e_rdy = e_rdy; t.e_qe = e_qe; t.e_idx = e_idx; t.e_done = e_done;
        tbl.push_back(t);
    endfunction

    function automatic logic [32*NW-1:0] fill_key(input logic [31:0] w);
        logic [32*NW-1:0] k;
        for (int i = 0; i < NW; i++) k[32*i +: 32] = w;
        return k;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, v, c, input logic [32*NW-1:0] k, input int tbl_rdy);
        int          kd;
        logic        eqe;
        logic [31:0] w, m;
        kd  = kind[cyc];
        eqe = (kd == K_WR) || (kd == K_CL);
        chk("qe", 32'(ks_qe_o), 32'(eqe));
        chk("busy", 32'(busy_o), 32'(eqe));
        chk("done", 32'(done_o), 32'(kd == K_DN));
        chk("idx", 32'(ks_idx_o), eqe ? 32'(eidx[cyc]) : 32'h0);
        if (kd == K_WR) begin
            w = eword[cyc];
`ifdef AES_KSL_MASK_EN
            m = lfsr_m;
            lfsr_m = lfsr_next(lfsr_m);
            chk("ks1_mask", ks1_q_o, m);
            chk("ks0_mask", ks0_q_o, w ^ m);
            chk("ks0_not_raw", 32'(ks0_q_o != w), 32'h1);
`else
            m = 32'h0;
            chk("ks1_plain", ks1_q_o, m);
            chk("ks0_plain", ks0_q_o, w);
`endif
        end else begin
            chk("ks0_zero", ks0_q_o, 32'h0);
            chk("ks1_zero", ks1_q_o, 32'h0);
        end
        obs_ks0[cyc] = ks0_q_o;
        obs_ks1[cyc] = ks1_q_o;

        rst = r; vld = v; clr = c; key = k;
        #1;
        chk("ready", 32'(key_ready_o), 32'(!r && kd == K_FREE));
        if (tbl_rdy >= 0) chk("tbl_rdy", 32'(key_ready_o), 32'(tbl_rdy));

        if (r) begin
            for (int j = 1; j <= NW + 2; j++) kind[cyc + j] = K_FREE;
`ifdef AES_KSL_MASK_EN
            lfsr_m = SEED;
`endif
        end else if (c && kd != K_CL) begin
            for (int j = 1; j <= NW; j++) begin
                kind[cyc + j] = K_CL;
                eidx[cyc + j] = j - 1;
            end
            kind[cyc + NW + 1] = K_DN;
        end else if (v && !c && kd == K_FREE) begin
            for (int j = 1; j <= NW; j++) begin
                kind[cyc + j]  = K_WR;
                eidx[cyc + j]  = j - 1;
                eword[cyc + j] = k[32*(j-1) +: 32];
            end
            kind[cyc + NW + 1] = K_DN;
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ta, tb2, tr;
        logic [32*NW-1:0] key_a, key_b, kr;
        logic [31:0] m;
        n_chk = 0; n_fail = 0; cyc = 0;
        lfsr_m = SEED;
        for (int i = 0; i < MAXC; i++) begin
            kind[i] = K_FREE; eidx[i] = 0; eword[i] = '0;
        end
        key_a = fill_key(32'hFFFF_FFFC);
        key_b = fill_key(32'h0000_0001);

        // Directed vectors: {rst, valid, clear, key, ready, qe, idx, done}
        add(1,0,0,0, 0,0,0,0); add(1,0,0,0, 0,0,0,0);
        for (int i = 0; i < 10; i++) add(0,0,0,0, 1,0,0,0);
        ta = tbl.size();
        add(0,1,0,1, 1,0,0,0);
        for (int j = 0; j < 8; j++) add(0,1,0,2, 0,1,j,0);
        add(0,1,0,2, 0,0,0,1);
        tb2 = tbl.size();
        add(0,1,0,2, 1,0,0,0);
        add(0,0,0,0, 0,1,0,0); add(0,0,0,0, 0,1,1,0);
        add(0,0,1,0, 0,1,2,0);
        for (int j = 0; j < 8; j++) add(0, j == 5, j == 3, 1, 0,1,j,0);
        add(0,0,0,0, 0,0,0,1);
        add(0,1,1,1, 1,0,0,0);
        for (int j = 0; j < 8; j++) add(0,1,0,1, 0,1,j,0);
        add(0,1,0,1, 0,0,0,1);
        add(0,1,0,1, 1,0,0,0);
        for (int j = 0; j < 3; j++) add(0,0,0,0, 0,1,j,0);
        add(1,0,0,0, 0,1,3,0);
        tr = tbl.size();
        add(0,1,0,1, 1,0,0,0);
        for (int j = 0; j < 8; j++) add(0,0,0,0, 0,1,j,0);
        add(0,0,0,0, 0,0,0,1);
        add(0,0,0,0, 1,0,0,0);

        @(posedge clk);
        #2;
        foreach (tbl[i]) begin
            chk("tbl_qe", 32'(ks_qe_o), 32'(tbl[i].e_qe));
            chk("tbl_busy", 32'(busy_o), 32'(tbl[i].e_qe));
            chk("tbl_idx", 32'(ks_idx_o), 32'(tbl[i].e_idx));
            chk("tbl_done", 32'(done_o), 32'(tbl[i].e_done));
            step(tbl[i].r, tbl[i].v, tbl[i].c,
                 (tbl[i].ksel == 1) ? key_a : ((tbl[i].ksel == 2) ? key_b : '0),
                 tbl[i].e_rdy);
        end

`ifdef AES_KSL_MASK_EN
        chk("w0_ks1", obs_ks1[ta + 1], 32'hACE1_2468);
        chk("w0_ks0", obs_ks0[ta + 1], 32'h531E_DB94);
        for (int j = 1; j <= NW; j++) chk("xor_a", obs_ks0[ta + j] ^ obs_ks1[ta + j], 32'hFFFF_FFFC);
        m = SEED;
        for (int j = 0; j < NW; j++) m = lfsr_next(m);
        chk("b2b_ks1", obs_ks1[tb2 + 1], m);
        chk("b2b_xor", obs_ks0[tb2 + 1] ^ obs_ks1[tb2 + 1], 32'h0000_0001);
        chk("reseed_ks1", obs_ks1[tr + 1], 32'hACE1_2468);
`else
        m = 32'h0;
        chk("w0_ks1", obs_ks1[ta + 1], m);
        chk("w0_ks0", obs_ks0[ta + 1], 32'hFFFF_FFFC);
        chk("b2b_ks0", obs_ks0[tb2 + 1], 32'h0000_0001);
        chk("reseed_ks0", obs_ks0[tr + 1], 32'hFFFF_FFFC);
`endif

        for (int i = 0; i < 1500; i++) begin
            for (int w = 0; w < NW; w++) kr[32*w +: 32] = $urandom;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0, kr, -1);
        end
        for (int i = 0; i < NW + 3; i++) step(1'b0, 1'b0, 1'b0, '0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_share_loader.md
# aes_key_share_loader

Upstream feeder for `aes_core` key registers. Accepts a full AES key over a valid/ready handshake and splits each 32-bit word into two Boolean shares, share1 = LFSR mask and share0 = key ^ mask. It then writes the shares word-by-word onto the `key_share0[i]`/`key_share1[i]` register strobes (`q` plus `qe`) and can also zeroise all key share registers on request. It replaces direct software pokes of the key shares and ensures no raw key word ever appears on a share bus when masking is enabled.

## Interface
Parameters:
- `NumWords`, default 8: number of 32-bit key words written (4/6/8 for AES-128/192/256).
- `LfsrSeed`, default 32'hACE1_2468: LFSR reset state; a value of 0 is replaced by 32'h0000_0001.

Ports:
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `key_valid_i` input 1: key on `key_i` is valid.
- `key_ready_o` output 1: loader can accept a key.
- `key_i` input 32*NumWords: key; word n = `key_i[32n +: 32]`.
- `clear_i` input 1: request zeroisation of all share registers.
- `ks0_q_o` output 32: share0 word (to `key_share0[idx].q`).
- `ks1_q_o` output 32: share1 word (to `key_share1[idx].q`).
- `ks_idx_o` output $clog2(NumWords): target word index.
- `ks_qe_o` output 1: write strobe for both shares at `ks_idx_o`.
- `busy_o` output 1: write or clear sequence in progress.
- `done_o` output 1: one-cycle pulse at the end of a key or clear sequence.

## Operation
- FSM states: IDLE, WRITE, CLEAR, DONE.
- IDLE: `key_ready_o`=1. On `key_valid_i && key_ready_o`, capture `key_i` into an internal register and go to WRITE with idx=0.
- WRITE: each cycle drive `ks_qe_o`=1, `ks_idx_o`=idx, `ks1_q_o`=LFSR state, `ks0_q_o`=key word[idx] ^ LFSR state.
  - Advance the LFSR and increment idx.
  - After idx=NumWords-1, go to DONE.
- CLEAR: same cadence as WRITE, but `ks0_q_o`=`ks1_q_o`=0 and the LFSR does not advance. After idx=NumWords-1, go to DONE.
- DONE: `done_o`=1 for one cycle, clear the captured key register to 0, return to IDLE.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shift right, XOR mask when the shifted-out LSB is 1.
  - Reset to the seed.
  - Unaffected by `clear_i`.
- `clear_i` has priority over everything:
  - In IDLE, including a cycle where `key_valid_i` is also high: the key is not accepted.
  - In WRITE: aborts immediately.
  - In DONE: the done pulse still fires, and CLEAR starts the next cycle.
  - In all of the above, the next state is CLEAR with idx=0, and the captured key is zeroed.
- `clear_i` during CLEAR is ignored; the sequence is not restarted.
- `key_valid_i` outside IDLE is ignored and not queued.

## Timing
- Reset values: `key_ready_o`=0 while `rst_i`=1, then 1 from the first cycle after reset deasserts. All other outputs are 0, and idx, FSM state and captured key are also 0.
- All outputs except `key_ready_o` are registered. `key_ready_o` = (state==IDLE) && !`rst_i`.
- Accept at cycle T gives `ks_qe_o`=1 on cycles T+1..T+NumWords with idx 0..NumWords-1 in order, then `done_o` at T+NumWords+1. The next accept is possible at T+NumWords+2.
- `busy_o`=1 exactly in WRITE and CLEAR.
- A clear request at cycle C gives zero writes on C+1..C+NumWords and `done_o` at C+NumWords+1.
- Idx wraps only by FSM exit; it never exceeds NumWords-1.
- `rst_i` mid-sequence returns to IDLE the next cycle with no further strobes. The LFSR is reseeded.

## Configuration
- `AES_KSL_MASK_EN` defined: shares are masked as described above.
- `AES_KSL_MASK_EN` undefined: the LFSR is removed, `ks1_q_o`=0 and `ks0_q_o`=key word. This debug mode exists to check `aes_core` with plaintext shares. Handshake and timing are identical.

## Test plan
- Reset release, idle: with NumWords=8, `key_valid_i`=0 for 10 cycles -> `key_ready_o`=1, `ks_qe_o`=0, `done_o`=0 throughout.
- Masked load (MASK_EN): key words all 32'hFFFF_FFFC, accepted at T -> 8 strobes idx 0..7 on T+1..T+8.
  - Word 0: `ks1_q_o`=32'hACE1_2468, `ks0_q_o`=32'h531E_DB94.
  - Every word: `ks0_q_o`^`ks1_q_o`=32'hFFFF_FFFC, and `ks0_q_o`≠key.
  - `done_o` at T+9.
- Back-to-back loads: a second key 32'h0000_0001 per word presented continuously -> accepted at T+10. Word 0 `ks1_q_o` equals the LFSR continuation (no reseed), and the XOR of the shares is still 1.
- Abort mid-write: `clear_i` on the third WRITE cycle -> the next 8 cycles strobe idx 0..7 with both shares 0, then one `done_o`. There are no further nonzero writes.
- Simultaneous `clear_i` and `key_valid_i` in IDLE -> key not accepted; zeroise sequence runs. `key_ready_o`=0 until after `done_o`.
- Reset mid-sequence: `rst_i` on the fourth WRITE cycle -> next cycle all outputs are 0 and the LFSR is reseeded. The next load's word 0 `ks1_q_o`=32'hACE1_2468.
